// File: rtl/snake_body_ctrl_if.sv
// Purpose: groups the game-control, direction, eat, render-query and status signals of snake_body_ctrl.
// Latency: none; this is wiring only.
// Backpressure: none; all signals are level or single-cycle pulses.
interface snake_body_ctrl_if;
    logic [1:0] mode;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       eat_;
    logic [5:0] scan_x;
    logic [5:0] scan_y;
    logic       is_body;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [5:0] snake_len;
    logic       step;
    logic       game_over;

    // Game/test side: drives controls and render queries, observes snake state.
    modport master (
        output mode, btn_up, btn_down, btn_left, btn_right, eat_, scan_x, scan_y,
        input  is_body, head_x, head_y, snake_len, step, game_over
    );

    // Snake body controller side.
    modport slave (
        input  mode, btn_up, btn_down, btn_left, btn_right, eat_, scan_x, scan_y,
        output is_body, head_x, head_y, snake_len, step, game_over
    );
endinterface

// File: rtl/snake_body_ctrl.sv
// Purpose: snake motion, body storage, growth and wall/self collision on a 40x30 grid; answers body queries.
// Latency: new head and step pulse appear one cycle after the tick evaluation; is_body is combinational.
// Backpressure: none; buttons and eat are sampled every cycle, steps are paced by the internal tick counter.
module snake_body_ctrl #(
    parameter int MAX_LEN   = 16,
    parameter int TICK_DIV  = 12500000,
    parameter int START_X   = 10,
    parameter int START_Y   = 15,
    parameter int START_LEN = 3
) (
    input  logic               clk_50MHz,
    input  logic               rst,
    snake_body_ctrl_if.slave   bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_e;

    logic [5:0]       seg_x_q [MAX_LEN];
    logic [5:0]       seg_y_q [MAX_LEN];
    dir_e             dir_q;
    dir_e             pend_q, pend_d;
    logic [5:0]       len_q;
    logic             grow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             step_q;
    state_e           state_q, state_d;

    logic             init;
    logic             tick;
    logic             cnt_en;
    logic             game_over;
    logic             req_vld;
    dir_e             req_dir;
    dir_e             opp_dir;
    logic [5:0]       nh_x, nh_y;
    logic             wall_hit;
    logic             self_hit;
    logic             growing;
    logic             move;
    logic             die;
    logic             is_body;

    // Leaving play mode behaves exactly like reset, so both collapse into one init condition.
    assign init = rst || (bus.mode != 2'd1);
    assign tick = cnt_en && (cnt_q == CNT_W'(TICK_DIV - 1));

    // FSM state register.
    always_ff @(posedge clk_50MHz) begin
        if (init) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any collision at a step is fatal until re-initialised.
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_RUN) && die) begin
            state_d = ST_DEAD;
        end
    end

    // FSM outputs: counting only while running, game_over is the DEAD level.
    always_comb begin
        cnt_en    = (state_q == ST_RUN);
        game_over = (state_q == ST_DEAD);
    end

    // Step pacing counter; frozen while dead.
    always_ff @(posedge clk_50MHz) begin
        if (init) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else if (cnt_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Button decode: highest-priority request wins, reversal onto the body is dropped.
    always_comb begin
        req_vld = 1'b1;
        req_dir = DIR_RIGHT;
        if (bus.btn_up) begin
            req_dir = DIR_UP;
        end else if (bus.btn_down) begin
            req_dir = DIR_DOWN;
        end else if (bus.btn_left) begin
            req_dir = DIR_LEFT;
        end else if (bus.btn_right) begin
            req_dir = DIR_RIGHT;
        end else begin
            req_vld = 1'b0;
        end
        // Encoding pairs opposites on bit 0 (UP/DOWN, LEFT/RIGHT).
        opp_dir = dir_e'(dir_q ^ 2'b01);
        pend_d  = pend_q;
        if (req_vld && (req_dir != opp_dir)) begin
            pend_d = req_dir;
        end
    end

    // Candidate head one cell along the pending direction; walls sit before any underflow/overflow.
    always_comb begin
        nh_x = seg_x_q[0];
        nh_y = seg_y_q[0];
        case (pend_q)
            DIR_UP:    nh_y = seg_y_q[0] - 6'd1;
            DIR_DOWN:  nh_y = seg_y_q[0] + 6'd1;
            DIR_LEFT:  nh_x = seg_x_q[0] - 6'd1;
            default:   nh_x = seg_x_q[0] + 6'd1;
        endcase
        wall_hit = (nh_x == 6'd0) || (nh_x == 6'd39) || (nh_y == 6'd0) || (nh_y == 6'd29);
    end

    // Self collision: the tail cell is vacated unless this step grows, so it only counts when growing.
    always_comb begin
        growing  = (grow_q || bus.eat_) && (len_q < 6'(MAX_LEN));
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((6'(i) + 6'd1 < len_q) || (growing && (6'(i) + 6'd1 == len_q))) &&
                (seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y)) begin
                self_hit = 1'b1;
            end
        end
        move = tick && !(wall_hit || self_hit);
        die  = tick &&  (wall_hit || self_hit);
    end

    // Direction, pending direction, growth flag, length and the registered step pulse.
    always_ff @(posedge clk_50MHz) begin
        if (init) begin
            dir_q  <= DIR_RIGHT;
            pend_q <= DIR_RIGHT;
            len_q  <= 6'(START_LEN);
            grow_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            step_q <= move;
            if (move) begin
                dir_q  <= pend_q;
                grow_q <= 1'b0;
                if (growing) begin
                    len_q <= len_q + 6'd1;
                end
            end else if (cnt_en) begin
                grow_q <= grow_q || bus.eat_;
            end
        end
    end

    // Segment shift register: head enters at index 0, everything moves down one slot.
    always_ff @(posedge clk_50MHz) begin
        if (init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < START_LEN) ? 6'(START_X - i) : 6'd0;
                seg_y_q[i] <= 6'(START_Y);
            end
        end else if (move) begin
            seg_x_q[0] <= nh_x;
            seg_y_q[0] <= nh_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
            end
        end
    end

    // Renderer query: only live segments may match; stale slots beyond len are ignored.
    always_comb begin
        is_body = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((6'(i) < len_q) && (seg_x_q[i] == bus.scan_x) && (seg_y_q[i] == bus.scan_y)) begin
                is_body = 1'b1;
            end
        end
    end

    assign bus.is_body   = is_body;
    assign bus.head_x    = seg_x_q[0];
    assign bus.head_y    = seg_y_q[0];
    assign bus.snake_len = len_q;
    assign bus.step      = step_q;
    assign bus.game_over = game_over;

endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
- Upstream of the apple/eating stage; owns snake motion and body storage on the 40x30 play grid.
- Advances the head one cell per step tick in the latched direction and grows the body on an eat pulse from the eating stage.
- Detects wall and self collisions, and answers per-pixel body-membership queries for the VGA renderer.

Parameters:
- MAX_LEN, 16: body segment capacity (2..32).
- TICK_DIV, 12500000: clk_50MHz cycles per step (4 steps/s).
- START_X, 10: initial head x.
- START_Y, 15: initial head y.
- START_LEN, 3: initial length (2..MAX_LEN, START_X-START_LEN+1 >= 1).

Ports:
- clk_50MHz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  game mode; 1 = playing, any other value = hold in start position.
- btn_up / btn_down / btn_left / btn_right  in  1 each  direction requests, already synchronised and debounced.
- eat_  in  1  one-cycle pulse from the eating stage.
- scan_x / scan_y  in  6 each  cell queried by the renderer.
- is_body  out  1  combinational; 1 if (scan_x,scan_y) equals any live segment 0..len-1.
- head_x / head_y  out  6 each  segment 0 position.
- snake_len  out  6  live segment count.
- step  out  1  one-cycle pulse, high in the cycle a new head value first appears.
- game_over  out  1  level; set on collision.

Behaviour:
Reset and mode:
- Reset state applies when rst=1, or when mode!=1 and rst=0. rst has priority.
- Reset state: seg[i] = (START_X-i, START_Y) for i < START_LEN; dir = RIGHT; pending dir = RIGHT; len = START_LEN; grow_pending = 0; tick counter = 0; step = 0; game_over = 0; state = RUN.
- Resulting outputs: head = (START_X, START_Y); snake_len = START_LEN; step = 0; game_over = 0.
- Dropping mode mid-run re-initialises on the next clock edge.

States:
- RUN: tick counter counts 0..TICK_DIV-1. In the cycle it equals TICK_DIV-1 it wraps to 0 and a step is evaluated.
- DEAD: counter frozen, segments/len/head frozen, game_over = 1. Only the reset state leaves DEAD.

Direction:
- Coordinates: up = y-1, down = y+1, left = x-1, right = x+1.
- Any asserted button overwrites pending dir. Same-cycle priority: up > down > left > right.
- A request opposite to the current dir (the one used at the last step) is discarded.
- At each step, dir <= pending dir.

Eat:
- eat_ = 1 sets grow_pending.
- grow_pending clears at the step that consumes it.
- eat_ in the same cycle as a step counts for that step.

Step evaluation (next head nh from new dir):
- Wall hit: nh.x == 0, nh.x == 39, nh.y == 0 or nh.y == 29.
- Self hit: nh equals seg[i] for i in 0..len-2. If growing (grow_pending and len < MAX_LEN), i extends to len-1.
- On any hit: state <= DEAD, game_over <= 1, no shift, step stays 0.
- Otherwise: seg[i+1] <= seg[i] for all i, seg[0] <= nh, step <= 1 for the following cycle (registered with the new head).
- Growing: len <= len+1. At len == MAX_LEN the eat is consumed with no growth.
- Segments at index >= len hold don't-care values and must never drive is_body.

Widths: all coordinates are 6-bit unsigned; no wrap-around, because walls are checked before any move.

Test Plan:
- TICK_DIV=4, rst then mode=1 -> head (10,15), len 3. After 4 cycles: step pulse, head (11,15); is_body true at (9,15) and (10,15), false at (8,15).
- btn_left while moving right -> ignored, next head (12,15). btn_up then btn_right in a later cycle before the step -> pending right, head x+1. btn_up+btn_left in the same cycle -> up wins, head y-1.
- eat_ pulse one cycle before a step -> len 4, previous tail cell still is_body. eat_ coincident with a step -> same growth. Eat at len 16 -> len stays 16.
- Move right from head (38,15) -> game_over=1, head stays (38,15), no step pulses for 20 ticks. mode 1->0->1 -> head (10,15), len 3, game_over 0.
- Len 5, head (20,15) moving right; up, left, down -> third move targets (19,15) = seg[3] -> game_over. Same with len 4 (target is the vacating tail) -> no collision, head (19,15).
- rst asserted during DEAD and mid-count -> next cycle head (10,15), counter 0, game_over 0, step 0.
